// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data and backing-memory signals of mem_port_arbiter.
//               Names are given from the arbiter's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              err_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_ack_i, mem_rdata_i,
        output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, err_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
    );

    modport master (
        output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
               mem_ack_i, mem_rdata_i,
        input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, err_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between fetch and MEM-stage
//               data requesters; drives the pipeline stall and aborts accesses
//               that are never acknowledged. Define ARB_RR_EN for round-robin
//               priority instead of fixed data-over-fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_dm_q, owner_dm_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              grant_dm;

`ifdef ARB_RR_EN
    logic              last_dm_q, last_dm_d;

    // On a tie the requester that was not granted last wins.
    assign grant_dm = bus.dm_req_i & (~bus.if_req_i | ~last_dm_q);
`else
    assign grant_dm = bus.dm_req_i;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_dm_d  = owner_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
`ifdef ARB_RR_EN
        last_dm_d   = last_dm_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.if_req_i || bus.dm_req_i) begin
                    owner_dm_d  = grant_dm;
                    mem_req_d   = 1'b1;
                    mem_we_d    = grant_dm & bus.dm_we_i;
                    mem_addr_d  = grant_dm ? bus.dm_addr_i : bus.if_addr_i;
                    mem_wdata_d = grant_dm ? bus.dm_wdata_i : '0;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
`ifdef ARB_RR_EN
                    last_dm_d   = grant_dm;
`endif
                end
            end
            S_WAIT: begin
                if (bus.mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = S_RESP;
                    if (owner_dm_q) begin
                        dm_ack_d = 1'b1;
                        if (!mem_we_q) dm_rdata_d = bus.mem_rdata_i;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata_i;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: complete the access with an error and zero data.
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_RESP;
                    if (owner_dm_q) begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_dm_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_dm_q  <= owner_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

`ifdef ARB_RR_EN
    // Resets to "fetch granted last" so data wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) last_dm_q <= 1'b0;
        else       last_dm_q <= last_dm_d;
    end
`endif

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.dm_ack_o    = dm_ack_q;
    assign bus.err_o       = err_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.stall_o     = (bus.if_req_i & ~if_ack_q) | (bus.dm_req_i & ~dm_ack_q);
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a latency-configurable
//               memory model; honours ARB_RR_EN when choosing grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 64;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } xact_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    xact_t       grant_q[$];
    xact_t       ack_q[$];
    logic [31:0] mem_model[logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 1;
    int          inject_ack = 0;
    int          ack_count_if = 0;
    int          ack_count_dm = 0;

    function automatic logic [31:0] rd_value(input logic [31:0] addr);
        return mem_model.exists(addr) ? mem_model[addr] : ~addr;
    endfunction

    function automatic void push_exp(input logic is_dm, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic err, input bit acked);
        xact_t e;
        e.is_dm = is_dm; e.we = we; e.addr = addr; e.wdata = wdata; e.err = err;
        e.rdata = err ? 32'h0 : (we ? 32'h0 : rd_value(addr));
        grant_q.push_back(e);
        if (acked) ack_q.push_back(e);
    endfunction

    // Memory: acks after mem_lat WAIT cycles seen at the falling edge (-1 = never).
    task automatic memory_model();
        int wcnt;
        wcnt = 0;
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack_i = 1'b0;
            if (inject_ack > 0) begin
                bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_0BAD; inject_ack--;
            end else if (bus.mem_req_o && !rst) begin
                if (mem_lat >= 0 && wcnt == mem_lat) begin
                    bus.mem_ack_i = 1'b1;
                    if (bus.mem_we_o) mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
                    else              bus.mem_rdata_i = rd_value(bus.mem_addr_o);
                end
                wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    endtask

    task automatic monitor();
        xact_t e; logic [31:0] rd; logic prev_req; logic [31:0] hold_addr;
        prev_req = 1'b0; hold_addr = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_o && !prev_req) begin
                checks++;
                if (grant_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_grant: addr=%h, expected no grant", bus.mem_addr_o);
                end else begin
                    e = grant_q.pop_front();
                    checks++;
                    if (bus.mem_addr_o !== e.addr || bus.mem_we_o !== e.we ||
                        (e.we && bus.mem_wdata_o !== e.wdata)) begin
                        errors++;
                        $display("FAIL grant: addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                                 bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o, e.addr, e.we, e.wdata);
                    end
                end
                hold_addr = bus.mem_addr_o;
            end else if (bus.mem_req_o) begin
                checks++;
                if (bus.mem_addr_o !== hold_addr) begin
                    errors++; $display("FAIL mem_addr_stable: got %h, expected %h", bus.mem_addr_o, hold_addr);
                end
            end
            prev_req = bus.mem_req_o;
            if (bus.if_ack_o || bus.dm_ack_o) begin
                if (bus.if_ack_o) ack_count_if++;
                if (bus.dm_ack_o) ack_count_dm++;
                checks++;
                if (ack_q.size() == 0) begin
                    errors++; $display("FAIL unexpected_ack: if_ack=%b dm_ack=%b, expected none", bus.if_ack_o, bus.dm_ack_o);
                end else begin
                    e = ack_q.pop_front();
                    checks++;
                    if ({bus.if_ack_o, bus.dm_ack_o} !== {~e.is_dm, e.is_dm}) begin
                        errors++; $display("FAIL ack_owner: if/dm ack=%b%b, expected %b%b",
                                           bus.if_ack_o, bus.dm_ack_o, ~e.is_dm, e.is_dm);
                    end
                    if (!e.we || e.err) begin
                        rd = e.is_dm ? bus.dm_rdata_o : bus.if_rdata_o;
                        checks++;
                        if (rd !== e.rdata) begin
                            errors++; $display("FAIL ack_rdata: got %h, expected %h (addr %h)", rd, e.rdata, e.addr);
                        end
                    end
                    checks++;
                    if (bus.err_o !== e.err) begin
                        errors++; $display("FAIL ack_err: got %b, expected %b", bus.err_o, e.err);
                    end
                end
            end else if (bus.err_o !== 1'b0) begin
                checks++; errors++; $display("FAIL err_without_ack: err_o=%b, expected 0", bus.err_o);
            end
        end
    endtask

    task automatic fetch_req(input logic [31:0] addr);
        int n;
        bus.if_req_i = 1'b1; bus.if_addr_i = addr;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.if_ack_o && n < 300);
        checks++;
        if (bus.if_ack_o !== 1'b1) begin
            errors++; $display("FAIL if_ack_timeout: if_ack_o=%b after %0d cycles, expected 1", bus.if_ack_o, n);
        end
        bus.if_req_i = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit drop);
        int n;
        bus.dm_req_i = 1'b1; bus.dm_we_i = we; bus.dm_addr_i = addr; bus.dm_wdata_i = wdata;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.dm_ack_o && n < 300);
        checks++;
        if (bus.dm_ack_o !== 1'b1) begin
            errors++; $display("FAIL dm_ack_timeout: dm_ack_o=%b after %0d cycles, expected 1", bus.dm_ack_o, n);
        end
        if (drop) bus.dm_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_ack_o, bus.dm_ack_o,
             bus.err_o, bus.if_rdata_o, bus.dm_rdata_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: mem_req=%b addr=%h ack=%b%b err=%b, expected all 0",
                               bus.mem_req_o, bus.mem_addr_o, bus.if_ack_o, bus.dm_ack_o, bus.err_o);
        end
        bus.dm_req_i = 1'b1; #1;
        checks++;
        if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_high: got %b, expected 1", bus.stall_o); end
        bus.dm_req_i = 1'b0; #1;
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_low: got %b, expected 0", bus.stall_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic exp_stall, exp_ack;
        mem_model[32'h10] = 32'h8C22_0004;
        mem_lat = 1;
        push_exp(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h10;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_stall = (k < 3);
            exp_ack   = (k == 3);
            checks++;
            if (bus.stall_o !== exp_stall) begin
                errors++; $display("FAIL fetch_stall_c%0d: got %b, expected %b", k, bus.stall_o, exp_stall);
            end
            checks++;
            if (bus.if_ack_o !== exp_ack) begin
                errors++; $display("FAIL fetch_ack_c%0d: got %b, expected %b", k, bus.if_ack_o, exp_ack);
            end
            if (k == 1) begin
                checks++;
                if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h10 || bus.mem_we_o !== 1'b0) begin
                    errors++; $display("FAIL fetch_issue: req=%b addr=%h we=%b, expected 1 00000010 0",
                                       bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o);
                end
            end
            if (k == 3) begin
                checks++;
                if (bus.if_rdata_o !== 32'h8C22_0004) begin
                    errors++; $display("FAIL fetch_rdata: got %h, expected 8c220004", bus.if_rdata_o);
                end
            end
        end
        bus.if_req_i = 1'b0;
    endtask

    task automatic test_priority();
        mem_lat = 1;
        push_exp(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1);
`ifdef ARB_RR_EN
        push_exp(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
        push_exp(1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 1'b0, 1'b1);
`else
        push_exp(1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 1'b0, 1'b1);
        push_exp(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
`endif
        repeat (2) @(negedge clk);
        fork
            begin
                data_req(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
                data_req(1'b1, 32'h104, 32'hCAFE_F00D, 1'b1);
            end
            fetch_req(32'h20);
        join
    endtask

    task automatic test_back_to_back();
        int a0, g;
        mem_model[32'h4] = 32'h1111_0004;
        mem_model[32'h8] = 32'h2222_0008;
        mem_lat = 2;
        a0 = ack_count_dm;
        push_exp(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1);
        push_exp(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        data_req(1'b0, 32'h4, 32'h0, 1'b0);
        bus.dm_addr_i = 32'h8;
        // RESP then the IDLE arbitration cycle before the next memory request.
        g = 0;
        while (!bus.mem_req_o && g < 10) begin g++; @(negedge clk); end
        checks++;
        if (g !== 2) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles, expected 2", g); end
        data_req(1'b0, 32'h8, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (ack_count_dm - a0 !== 2) begin
            errors++; $display("FAIL b2b_ack_count: got %0d, expected 2", ack_count_dm - a0);
        end
    endtask

    task automatic test_long_latency();
        int a0, n, w;
        mem_model[32'h40] = 32'h4040_4040;
        mem_lat = 10;
        a0 = ack_count_dm;
        push_exp(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h40;
        n = 0; w = 0;
        do begin
            @(negedge clk); n++;
            if (bus.mem_req_o) w++;
            if (!bus.dm_ack_o) begin
                checks++;
                if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL long_stall: got %b, expected 1 (cycle %0d)", bus.stall_o, n); end
            end
        end while (!bus.dm_ack_o && n < 60);
        bus.dm_req_i = 1'b0;
        checks++;
        if (w !== 11) begin errors++; $display("FAIL long_wait_cycles: got %0d, expected 11", w); end
        repeat (4) @(negedge clk);
        checks++;
        if (ack_count_dm - a0 !== 1) begin
            errors++; $display("FAIL long_ack_count: got %0d, expected 1", ack_count_dm - a0);
        end
    endtask

    task automatic test_timeout();
        int n, w;
        mem_lat = -1;
        push_exp(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_addr_i = 32'h200;
        n = 0;
        while (!bus.mem_req_o && n < 10) begin @(negedge clk); n++; end
        w = 0;
        while (bus.mem_req_o && w < 200) begin @(negedge clk); w++; end
        checks++;
        if (w !== TIMEOUT_CYC) begin errors++; $display("FAIL timeout_wait_cycles: got %0d, expected %0d", w, TIMEOUT_CYC); end
        checks++;
        if (bus.dm_ack_o !== 1'b1 || bus.err_o !== 1'b1 || bus.dm_rdata_o !== 32'h0) begin
            errors++; $display("FAIL timeout_resp: ack=%b err=%b rdata=%h, expected 1 1 00000000",
                               bus.dm_ack_o, bus.err_o, bus.dm_rdata_o);
        end
        bus.dm_req_i = 1'b0;
        mem_lat = 1;
    endtask

    task automatic test_reset_mid_wait();
        int n, a_if;
        mem_lat = -1;
        a_if = ack_count_if;
        push_exp(1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
        n = 0;
        while (!bus.mem_req_o && n < 10) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        rst = 1'b1; bus.if_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        inject_ack = 1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.mem_req_o !== 1'b0 || bus.if_ack_o !== 1'b0 || bus.dm_ack_o !== 1'b0) begin
                errors++; $display("FAIL reset_mid_wait_c%0d: mem_req=%b ack=%b%b, expected 0 00",
                                   k, bus.mem_req_o, bus.if_ack_o, bus.dm_ack_o);
            end
            @(negedge clk);
        end
        checks++;
        if (ack_count_if !== a_if) begin errors++; $display("FAIL reset_mid_wait_ack: got %0d acks, expected 0", ack_count_if - a_if); end
        mem_lat = 1;
    endtask

    initial begin
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
        fork
            memory_model();
            monitor();
        join_none
        test_reset();
        test_single_fetch();
        test_priority();
        test_back_to_back();
        test_long_latency();
        test_timeout();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        checks++;
        if (ack_q.size() != 0 || grant_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d acks and %0d grants left, expected 0 and 0", ack_q.size(), grant_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
